// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 serializer on the UART TX pin.
// Exposes full/empty/level status and a sticky overflow flag.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 234,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  clr_ovf,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  busy,
  output logic                  tx
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0] FULL_LVL =
    (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t r_state, w_state_nx;

  logic [CW-1:0]         r_cnt, w_cnt_nx;
  logic [2:0]            r_idx, w_idx_nx;
  logic [7:0]            r_shift, w_shift_nx;
  logic                  r_tx, w_tx_nx;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_ovf;

  logic w_pop, w_push, w_drop;
  logic w_bit_done, w_full, w_empty;

  assign w_full     = (r_level == FULL_LVL);
  assign w_empty    = (r_level == '0);
  assign w_bit_done = (r_cnt == LAST);
  assign w_push     = wr_en && (!w_full || w_pop);
  assign w_drop     = wr_en && w_full && !w_pop;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_shift_nx = r_shift;
    w_pop      = 1'b0;
    if (r_state != S_IDLE) begin
      w_cnt_nx = w_bit_done ? '0 : r_cnt + 1'b1;
    end
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_shift_nx = r_mem[r_rptr];
          w_state_nx = S_START;
        end
      end
      S_START: begin
        if (w_bit_done) begin
          w_state_nx = S_DATA;
          w_idx_nx   = '0;
        end
      end
      S_DATA: begin
        if (w_bit_done) begin
          w_shift_nx = {1'b0, r_shift[7:1]};
          w_idx_nx   = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_done) begin
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_shift_nx = r_mem[r_rptr];
            w_state_nx = S_START;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    // Line level follows the state being entered.
    unique case (w_state_nx)
      S_START: w_tx_nx = 1'b0;
      S_DATA:  w_tx_nx = w_shift_nx[0];
      default: w_tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_shift <= w_shift_nx;
      r_tx    <= w_tx_nx;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end

  assign full     = w_full;
  assign empty    = w_empty;
  assign level    = r_level;
  assign overflow = r_ovf;
  assign busy     = (r_state != S_IDLE);
  assign tx       = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a per-cycle vector table
// and a line monitor that decodes frames into a byte queue.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
  localparam int DL2 = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wr_en = 1'b0;
  logic [7:0]     wr_data = '0;
  logic           clr_ovf = 1'b0;
  logic           full, empty, overflow, busy, tx;
  logic [DL2:0]   level;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DEPTH_LOG2  (DL2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .clr_ovf (clr_ovf),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .overflow(overflow),
    .busy    (busy),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line monitor: samples one cycle into each bit.
  logic [7:0] rx_q [$];
  int         rx_t [$];

  initial begin : mon
    int         st;
    logic [9:0] bits;
    bit         ab;
    forever begin
      @(posedge clk);
      #1;
      if (tx === 1'b0 && busy === 1'b1) begin
        st   = cyc;
        bits = '0;
        ab   = 1'b0;
        for (int o = 1; o < 40; o++) begin
          @(posedge clk);
          #1;
          if (busy !== 1'b1) begin
            ab = 1'b1;
            break;
          end
          if (o % 4 == 1) bits[o / 4] = tx;
        end
        if (!ab) begin
          chk("start_bit", 32'(bits[0]), 32'd0);
          chk("stop_bit", 32'(bits[9]), 32'd1);
          rx_q.push_back(bits[8:1]);
          rx_t.push_back(st);
        end
      end
    end
  end

  typedef struct packed {
    logic       we;
    logic [7:0] wd;
    logic       clr;
    logic       tx;
    logic       busy;
    logic [4:0] lvl;
    logic       emp;
    logic       ful;
    logic       ovf;
  } vec_t;

  vec_t vt [$];

  function automatic vec_t mk(input logic we,
                              input logic [7:0] wd,
                              input logic t,
                              input logic b,
                              input logic [4:0] l,
                              input logic e);
    vec_t v;
    v.we   = we;
    v.wd   = wd;
    v.clr  = 1'b0;
    v.tx   = t;
    v.busy = b;
    v.lvl  = l;
    v.emp  = e;
    v.ful  = 1'b0;
    v.ovf  = 1'b0;
    return v;
  endfunction

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while ((busy || !empty) && n < maxc) begin
      step();
      n++;
    end
    chk("idle_timeout", 32'(n < maxc), 32'd1);
  endtask

  bit         a5_line [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  logic [7:0] t3 [3] = '{8'h55, 8'h0F, 8'hFF};

  initial begin : main
    int pk, t_on, t_s, n;
    bit bad;

    // Idle rows, then a single 0xA5 push and its whole frame.
    for (int i = 0; i < 20; i++)
      vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1));
    vt.push_back(mk(1'b1, 8'hA5, 1'b1, 1'b0, 5'd1, 1'b0));
    for (int i = 0; i < 40; i++)
      vt.push_back(mk(1'b0, 8'h00, a5_line[i / 4],
                      1'b1, 5'd0, 1'b1));
    vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1));

    step();
    step();
    chk("rst_state",
        {tx, busy, full, empty, overflow, 27'(level)},
        {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 27'd0});
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      wr_en   = vt[i].we;
      wr_data = vt[i].wd;
      clr_ovf = vt[i].clr;
      step();
      chk($sformatf("vec%0d", i),
          {tx, busy, 5'(level), empty, full, overflow},
          {vt[i].tx, vt[i].busy, vt[i].lvl,
           vt[i].emp, vt[i].ful, vt[i].ovf});
    end
    wr_en = 1'b0;
    chk("a5_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) chk("a5_byte", 32'(rx_q[0]), 32'hA5);

    // Three back-to-back frames.
    rx_q.delete();
    rx_t.delete();
    pk   = 0;
    t_on = -1;
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = t3[i];
      step();
      if (int'(level) > pk) pk = int'(level);
      if (busy && t_on < 0) t_on = cyc;
    end
    wr_en = 1'b0;
    n = 0;
    while (!(t_on >= 0 && !busy) && n < 300) begin
      step();
      n++;
      if (int'(level) > pk) pk = int'(level);
      if (busy && t_on < 0) t_on = cyc;
    end
    chk("b2b_timeout", 32'(n < 300), 32'd1);
    chk("b2b_peak", 32'(pk), 32'd2);
    chk("b2b_total", 32'(cyc - t_on), 32'd120);
    chk("b2b_count", 32'(rx_q.size()), 32'd3);
    if (rx_q.size() == 3) begin
      for (int i = 0; i < 3; i++)
        chk($sformatf("b2b_byte%0d", i), 32'(rx_q[i]), 32'(t3[i]));
      chk("b2b_gap0", 32'(rx_t[1] - rx_t[0]), 32'd40);
      chk("b2b_gap1", 32'(rx_t[2] - rx_t[1]), 32'd40);
    end

    // Overflow: 18 pushes while the line is busy.
    rx_q.delete();
    rx_t.delete();
    for (int i = 0; i < 18; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      step();
      if (i == 15) chk("ov_notfull", 32'(full), 32'd0);
      if (i == 16) begin
        chk("ov_full", 32'(full), 32'd1);
        chk("ov_lvl16", 32'(level), 32'd16);
        chk("ov_clean", 32'(overflow), 32'd0);
      end
      if (i == 17) begin
        chk("ov_set", 32'(overflow), 32'd1);
        chk("ov_lvl", 32'(level), 32'd16);
      end
    end
    wr_en = 1'b0;
    step();
    chk("ov_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ov_clr", 32'(overflow), 32'd0);
    wait_idle(1000);
    chk("ov_count", 32'(rx_q.size()), 32'd17);
    if (rx_q.size() == 17)
      for (int i = 0; i < 17; i++)
        chk($sformatf("ov_byte%0d", i), 32'(rx_q[i]), 32'(i));

    // Full FIFO, push on the cycle the stop bit completes.
    rx_q.delete();
    rx_t.delete();
    t_s = -1;
    for (int i = 0; i < 17; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'h80 + 8'(i);
      step();
      if (busy && t_s < 0) t_s = cyc;
    end
    wr_en = 1'b0;
    n = 0;
    while (cyc < t_s + 39 && n < 100) begin
      step();
      n++;
    end
    chk("pp_full_before", 32'(full), 32'd1);
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    step();
    wr_en = 1'b0;
    chk("pp_lvl", 32'(level), 32'd16);
    chk("pp_full", 32'(full), 32'd1);
    chk("pp_ovf", 32'(overflow), 32'd0);
    wait_idle(1200);
    chk("pp_count", 32'(rx_q.size()), 32'd18);
    if (rx_q.size() == 18) begin
      chk("pp_first", 32'(rx_q[0]), 32'h80);
      chk("pp_wrap", 32'(rx_q[16]), 32'h90);
      chk("pp_last", 32'(rx_q[17]), 32'hEE);
    end

    // Reset mid data bit 3 of 0x3C with two bytes queued.
    rx_q.delete();
    rx_t.delete();
    t_s = -1;
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = (i == 0) ? 8'h3C : 8'hA0 + 8'(i);
      step();
      if (busy && t_s < 0) t_s = cyc;
    end
    wr_en = 1'b0;
    n = 0;
    while (cyc < t_s + 17 && n < 100) begin
      step();
      n++;
    end
    chk("mr_bit3", 32'(tx), 32'd1);
    chk("mr_lvl_before", 32'(level), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_after",
        {tx, busy, empty, 29'(level)},
        {1'b1, 1'b0, 1'b1, 29'd0});
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    chk("mr_quiet", 32'(bad), 32'd0);
    chk("mr_noframes", 32'(rx_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
